// File: rtl/seven_seg_pkg.sv
// Purpose : shared constants and hex-to-segment decode for the seven-segment scan driver.
// Latency : n/a (package: types, constants, pure function).
// Backpressure: n/a.
// Contents: SEG_OFF (all segments dark, active-high), SEG_TABLE (abcdefg per hex value),
//           seg_decode() lookup helper.
package seven_seg_pkg;

  // All segments dark, active-high encoding (bit 6 = A ... bit 0 = G).
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Active-high abcdefg patterns for hex digits 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79,
    7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F,
    7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] val);
    return SEG_TABLE[val];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Purpose : combinational 4-bit hex value to active-high abcdefg segment pattern.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; output follows input every cycle.
// Ports   : i_val [3:0] hex value in; o_seg [6:0] segments out, o_seg[6]=A ... o_seg[0]=G.
module seg7_hex_decode (
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);
  import seven_seg_pkg::*;

  assign o_seg = seg_decode(i_val);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Purpose : time-multiplexed N-digit seven-segment driver with tear-free load/shadow data path.
// Latency : outputs registered, 1 cycle after the tick/digit/shadow state they reflect;
//           loaded data becomes visible from the first slot after the next frame boundary.
// Backpressure: none; i_load is always accepted, o_pending reports data waiting for a boundary.
// Ports   : i_clk, i_rst_n (sync, active-low); i_num[4N-1:0], i_dp_in[N-1:0], i_digit_en[N-1:0],
//           i_load in; o_pending, o_seg[6:0], o_dp, o_anode[N-1:0], o_frame_done out.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_DIV    = 100000,
  parameter int BLANK_CYCLES   = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [4*NUM_DIGITS-1:0]   i_num,
  input  logic [NUM_DIGITS-1:0]     i_dp_in,
  input  logic [NUM_DIGITS-1:0]     i_digit_en,
  input  logic                      i_load,
  output logic                      o_pending,
  output logic [6:0]                o_seg,
  output logic                      o_dp,
  output logic [NUM_DIGITS-1:0]     o_anode,
  output logic                      o_frame_done
);
  import seven_seg_pkg::*;

  localparam int TW = $clog2(REFRESH_DIV);
  // A single-digit display still needs a 1-bit index register.
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // XOR masks that turn active-high internal values into pin polarity.
  localparam logic [6:0]            SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_XOR  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_XOR  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  localparam logic [TW-1:0] TICK_LAST  = TW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

  // ---------------------------------------------------------------- scan state
  logic [TW-1:0] r_tick_cnt;
  logic [DW-1:0] r_digit_idx;

  logic w_slot_end;
  logic w_frame_boundary;

  assign w_slot_end       = (r_tick_cnt == TICK_LAST);
  assign w_frame_boundary = w_slot_end && (r_digit_idx == DIGIT_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tick_cnt  <= '0;
      r_digit_idx <= '0;
    end else begin
      if (w_slot_end) begin
        r_tick_cnt <= '0;
        if (r_digit_idx == DIGIT_LAST) begin
          r_digit_idx <= '0;
        end else begin
          r_digit_idx <= r_digit_idx + DW'(1);
        end
      end else begin
        r_tick_cnt <= r_tick_cnt + TW'(1);
      end
    end
  end

  // ---------------------------------------------------------------- load / shadow
  // Staging holds the latest load; shadow is what the scanner displays and only
  // changes on a frame boundary, so a frame is never drawn with mixed data.
  logic [4*NUM_DIGITS-1:0] r_stg_num;
  logic [NUM_DIGITS-1:0]   r_stg_dp;
  logic [NUM_DIGITS-1:0]   r_stg_en;
  logic [4*NUM_DIGITS-1:0] r_shd_num;
  logic [NUM_DIGITS-1:0]   r_shd_dp;
  logic [NUM_DIGITS-1:0]   r_shd_en;
  logic                    r_pending;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stg_num <= '0;
      r_stg_dp  <= '0;
      r_stg_en  <= '0;
      r_shd_num <= '0;
      r_shd_dp  <= '0;
      r_shd_en  <= '0;
      r_pending <= 1'b0;
    end else if (w_frame_boundary) begin
      // A load landing on the boundary itself bypasses staging; it is the
      // newest data, so it also beats anything already pending.
      if (i_load) begin
        r_shd_num <= i_num;
        r_shd_dp  <= i_dp_in;
        r_shd_en  <= i_digit_en;
      end else if (r_pending) begin
        r_shd_num <= r_stg_num;
        r_shd_dp  <= r_stg_dp;
        r_shd_en  <= r_stg_en;
      end
      r_pending <= 1'b0;
    end else if (i_load) begin
      r_stg_num <= i_num;
      r_stg_dp  <= i_dp_in;
      r_stg_en  <= i_digit_en;
      r_pending <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- digit select / decode
  logic [3:0]            w_sel_num;
  logic                  w_sel_dp;
  logic                  w_sel_en;
  logic [6:0]            w_dec_seg;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic                  w_in_blank_time;
  logic                  w_blank;

  assign w_sel_num = r_shd_num[{r_digit_idx, 2'b00} +: 4];
  assign w_sel_dp  = r_shd_dp[r_digit_idx];
  assign w_sel_en  = r_shd_en[r_digit_idx];
  assign w_onehot  = NUM_DIGITS'(1) << r_digit_idx;

  seg7_hex_decode u_dec (
    .i_val (w_sel_num),
    .o_seg (w_dec_seg)
  );

  // Anti-ghosting window at the start of each slot. With zero blank cycles
  // the compare would be constant, so it is left out entirely.
  generate
    if (BLANK_CYCLES > 0) begin : g_blank
      assign w_in_blank_time = (r_tick_cnt < TW'(BLANK_CYCLES));
    end else begin : g_noblank
      assign w_in_blank_time = 1'b0;
    end
  endgenerate

  assign w_blank = w_in_blank_time || !w_sel_en;

  logic [NUM_DIGITS-1:0] w_anode_nxt;
  logic [6:0]            w_seg_nxt;
  logic                  w_dp_nxt;

  always_comb begin
    w_anode_nxt = AN_XOR;
    w_seg_nxt   = SEG_OFF ^ SEG_XOR;
    w_dp_nxt    = DP_XOR;
    if (!w_blank) begin
      w_anode_nxt = w_onehot ^ AN_XOR;
      w_seg_nxt   = w_dec_seg ^ SEG_XOR;
      w_dp_nxt    = w_sel_dp ^ DP_XOR;
    end
  end

  // ---------------------------------------------------------------- output registers
  logic [NUM_DIGITS-1:0] r_anode;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic                  r_frame_done;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_anode      <= AN_XOR;
      r_seg        <= SEG_OFF ^ SEG_XOR;
      r_dp         <= DP_XOR;
      r_frame_done <= 1'b0;
    end else begin
      r_anode      <= w_anode_nxt;
      r_seg        <= w_seg_nxt;
      r_dp         <= w_dp_nxt;
      r_frame_done <= w_frame_boundary;
    end
  end

  assign o_anode      = r_anode;
  assign o_seg        = r_seg;
  assign o_dp         = r_dp;
  assign o_frame_done = r_frame_done;
  assign o_pending    = r_pending;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Purpose : self-checking bench for seven_seg_scan_driver (4 digits, 4-cycle slots, 1 blank cycle).
// Latency : expected outputs follow the DUT by the same registered cycle.
// Backpressure: n/a.
module tb_seven_seg_scan_driver;

  localparam int ND  = 4;
  localparam int DIV = 4;
  localparam int BLK = 1;
  localparam int FRAME = ND * DIV;

  localparam logic [6:0] HEX_TAB [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   num;
  logic [3:0]    dp_in;
  logic [3:0]    den;
  logic          load;
  logic          pending;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    anode;
  logic          frame_done;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS     (ND),
    .REFRESH_DIV    (DIV),
    .BLANK_CYCLES   (BLK),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_num        (num),
    .i_dp_in      (dp_in),
    .i_digit_en   (den),
    .i_load       (load),
    .o_pending    (pending),
    .o_seg        (seg),
    .o_dp         (dp),
    .o_anode      (anode),
    .o_frame_done (frame_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // ------------------------------------------------------------ reference model
  // Position in the scan is just elapsed cycles since reset; the displayed
  // data is the last load that reached a frame boundary.
  int          m_t = 0;
  bit          m_valid = 0;
  bit          m_pend;
  logic [15:0] m_stg_num, m_shd_num;
  logic [3:0]  m_stg_dp, m_shd_dp, m_stg_en, m_shd_en;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd, e_pend;

  always @(posedge clk) begin
    int tick, dig;
    bit fb;
    m_valid = 1;
    if (!rst_n) begin
      m_t = 0; m_pend = 0;
      m_stg_num = '0; m_stg_dp = '0; m_stg_en = '0;
      m_shd_num = '0; m_shd_dp = '0; m_shd_en = '0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0; e_pend = 1'b0;
    end else begin
      tick = m_t % DIV;
      dig  = (m_t / DIV) % ND;
      fb   = (m_t % FRAME) == FRAME - 1;
      if (tick < BLK || !m_shd_en[dig]) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an  = ~(4'b0001 << dig);
        e_seg = ~HEX_TAB[m_shd_num[dig*4 +: 4]];
        e_dp  = ~m_shd_dp[dig];
      end
      e_fd = fb;
      if (fb) begin
        if (load) begin
          m_shd_num = num; m_shd_dp = dp_in; m_shd_en = den;
        end else if (m_pend) begin
          m_shd_num = m_stg_num; m_shd_dp = m_stg_dp; m_shd_en = m_stg_en;
        end
        m_pend = 0;
      end else if (load) begin
        m_stg_num = num; m_stg_dp = dp_in; m_stg_en = den;
        m_pend = 1;
      end
      e_pend = m_pend;
      m_t++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("anode", {12'h0, anode}, {12'h0, e_an});
      chk("seg", {9'h0, seg}, {9'h0, e_seg});
      chk("dp", {15'h0, dp}, {15'h0, e_dp});
      chk("frame_done", {15'h0, frame_done}, {15'h0, e_fd});
      chk("pending", {15'h0, pending}, {15'h0, e_pend});
    end
  end

  // ------------------------------------------------------------ stimulus helpers
  // At a falling edge, m_t % FRAME is the scan position the next rising edge
  // acts on; the outputs visible now belong to position (m_t-1).
  task automatic goto_pos(input int p);
    int n = 0;
    while ((m_t % FRAME) != p && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if ((m_t % FRAME) != p) begin
      n_checks++;
      $display("FAIL goto_pos: got position %0d expected %0d", m_t % FRAME, p);
    end
  endtask

  task automatic pulse_load(input logic [15:0] n, input logic [3:0] d, input logic [3:0] e);
    num = n; dp_in = d; den = e; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // ------------------------------------------------------------ main sequence
  initial begin
    rst_n = 1'b0;
    num = 16'($urandom); dp_in = 4'($urandom); den = 4'($urandom); load = 1'($urandom);
    repeat (3) begin
      @(negedge clk);
      num = 16'($urandom); dp_in = 4'($urandom); den = 4'($urandom); load = 1'($urandom);
    end
    chk("rst_anode", {12'h0, anode}, 16'h000F);
    chk("rst_seg", {9'h0, seg}, 16'h007F);
    chk("rst_dp", {15'h0, dp}, 16'h0001);
    chk("rst_pending", {15'h0, pending}, 16'h0000);
    chk("rst_frame_done", {15'h0, frame_done}, 16'h0000);

    rst_n = 1'b1; load = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_blank_anode", {12'h0, anode}, 16'h000F);

    // Basic scan
    goto_pos(5);
    pulse_load(16'h3210, 4'b0100, 4'hF);
    chk("scan_pending_hi", {15'h0, pending}, 16'h0001);
    goto_pos(0);
    chk("scan_pending_lo", {15'h0, pending}, 16'h0000);
    chk("scan_frame_done", {15'h0, frame_done}, 16'h0001);
    goto_pos(1);
    chk("scan_blank_anode", {12'h0, anode}, 16'h000F);
    goto_pos(2);
    chk("scan_d0_anode", {12'h0, anode}, 16'h000E);
    chk("scan_d0_seg", {9'h0, seg}, 16'h0001);
    goto_pos(7);
    chk("scan_d1_anode", {12'h0, anode}, 16'h000D);
    chk("scan_d1_seg", {9'h0, seg}, 16'h004F);
    goto_pos(10);
    chk("scan_d2_anode", {12'h0, anode}, 16'h000B);
    chk("scan_d2_seg", {9'h0, seg}, 16'h0012);
    chk("scan_d2_dp", {15'h0, dp}, 16'h0000);
    goto_pos(14);
    chk("scan_d3_anode", {12'h0, anode}, 16'h0007);
    chk("scan_d3_seg", {9'h0, seg}, 16'h0006);
    chk("scan_d3_dp", {15'h0, dp}, 16'h0001);

    // Per-digit blanking
    goto_pos(5);
    pulse_load(16'h3210, 4'b0100, 4'b1010);
    goto_pos(0);
    goto_pos(2);
    chk("blank_d0_anode", {12'h0, anode}, 16'h000F);
    chk("blank_d0_seg", {9'h0, seg}, 16'h007F);
    goto_pos(6);
    chk("blank_d1_anode", {12'h0, anode}, 16'h000D);

    // Tear-free double load
    goto_pos(3);
    pulse_load(16'hFFFF, 4'h0, 4'hF);
    goto_pos(7);
    chk("tear_old_d1_seg", {9'h0, seg}, 16'h004F);
    goto_pos(9);
    pulse_load(16'hAAAA, 4'h0, 4'hF);
    chk("tear_pending_hi", {15'h0, pending}, 16'h0001);
    goto_pos(0);
    chk("tear_pending_lo", {15'h0, pending}, 16'h0000);
    goto_pos(2);
    chk("tear_d0_seg", {9'h0, seg}, 16'h0008);
    goto_pos(14);
    chk("tear_d3_seg", {9'h0, seg}, 16'h0008);

    // Load coincident with the frame boundary
    goto_pos(15);
    pulse_load(16'h5555, 4'h0, 4'hF);
    chk("coinc_pending", {15'h0, pending}, 16'h0000);
    goto_pos(2);
    chk("coinc_d0_seg", {9'h0, seg}, 16'h0024);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      num   = 16'($urandom);
      dp_in = 4'($urandom);
      den   = 4'($urandom);
      load  = ($urandom_range(7) == 0);
      rst_n = ($urandom_range(150) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1; load = 1'b0;
    repeat (5) @(negedge clk);

    // Mid-scan reset during digit 2
    goto_pos(5);
    pulse_load(16'h1234, 4'hF, 4'hF);
    goto_pos(9);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_anode", {12'h0, anode}, 16'h000F);
    chk("mrst_seg", {9'h0, seg}, 16'h007F);
    chk("mrst_pending", {15'h0, pending}, 16'h0000);
    rst_n = 1'b1;
    pulse_load(16'h0009, 4'h0, 4'hF);
    goto_pos(0);
    goto_pos(2);
    chk("mrst_d0_anode", {12'h0, anode}, 16'h000E);
    chk("mrst_d0_seg", {9'h0, seg}, 16'h0004);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
